multiplication: RTL and testbench
=================================

MULTIPLICATION -- requirements
Module: multiplication

Interface
REQ-001 Parameter WIDTH, default 24: total operand/result width, signed Q(WIDTH-FBITS).FBITS two's complement (Q16.8 at defaults).
REQ-002 Parameter FBITS, default 8: fractional bits, 1 <= FBITS < WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  WIDTH  signed multiplicand; captured on the accepting edge.
REQ-007 b  input  WIDTH  signed multiplier; captured on the accepting edge.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking result completion.
REQ-010 valid  output  1  val holds a correct in-range product.
REQ-011 ovf  output  1  product is out of representable range.
REQ-012 val  output  WIDTH  signed Q-format product.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, ROUND and SIGN.
REQ-014 IDLE with start=1 at edge k: latch |a|, |b| (WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1)), sign = a[MSB]^b[MSB], clear the 2*WIDTH accumulator and counter, busy=1, done=0, go to CALC.
REQ-015 CALC, edges k+1..k+WIDTH: one multiplier bit per edge, LSB first; add the shifted multiplicand when the bit is 1; after WIDTH iterations go to ROUND.
REQ-016 ROUND, edge k+WIDTH+1: add 2^(FBITS-1) to the accumulator, shift right by FBITS (round half away from zero on magnitude), and evaluate overflow.
REQ-017 Overflow SHALL be declared when the rounded magnitude exceeds 2^(WIDTH-1)-1 for a positive sign, or 2^(WIDTH-1) for a negative sign.
REQ-018 A zero rounded magnitude SHALL always yield val=0 with positive sign; -0 is never produced.
REQ-019 SIGN, edge k+WIDTH+2: for a non-overflow result, val = signed rounded magnitude, valid=1, ovf=0.
REQ-020 SIGN, edge k+WIDTH+2: for an overflow result, val=0, valid=0, ovf=1.
REQ-021 SIGN, edge k+WIDTH+2: in both cases done=1, busy=0, return to IDLE.
REQ-022 Latency SHALL be fixed at WIDTH+2 edges from acceptance to done (26 at defaults), independent of operand values, including zero operands.
REQ-023 done SHALL be high for exactly one cycle and low at the next edge.
REQ-024 val, valid and ovf SHALL hold their values until the next accepted start.
REQ-025 start while busy=1 SHALL be ignored; a and b changes during an operation SHALL have no effect.
REQ-026 start high in the cycle done=1 (FSM in IDLE) SHALL be accepted; back-to-back operations have no dead cycle.
REQ-027 On acceptance, valid and ovf SHALL clear at edge k.

Reset
REQ-028 rst=0 SHALL immediately, without a clock, force state IDLE, busy=0, done=0, valid=0, ovf=0, val=0, and clear the accumulator and counter.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first accepted start after release SHALL behave normally.

Structure
REQ-030 A shared fixed-point package SHALL hold the default WIDTH and FBITS values and the FSM state encoding, common with the division block.
REQ-031 The block SHALL be a single module with no sub-modules; the add-shift datapath is inline.

Verification
REQ-032 a=2560 (10.0), b=512 (2.0) -> done 26 cycles after start, val=5120, valid=1, ovf=0.
REQ-033 a=-2560, b=512 -> val=-5120; a=-640, b=-1024 -> val=2560; a=0, b=1280 -> val=0, valid=1.
REQ-034 Rounding: a=1, b=128 -> val=1; a=128, b=128 -> val=64 (0.25).
REQ-035 Range edges: a=8388352 (32767.0), b=512 -> ovf=1, valid=0, val=0; a=-8388608, b=256 -> val=-8388608, valid=1, ovf=0.
REQ-036 start pulsed mid-operation is ignored with unchanged latency; start in the done cycle is accepted; rst=0 at cycle 10 -> all outputs 0 at once, no done pulse.

Source files
------------

// File: rtl/multiplication_pkg.sv
// Shared fixed-point definitions: default Q-format widths and the
// sequential-arithmetic FSM state encoding.
package multiplication_pkg;

    localparam int FP_WIDTH = 24;
    localparam int FP_FBITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ROUND = 2'd2,
        ST_SIGN  = 2'd3
    } fp_state_e;

endpackage

// File: rtl/multiplication.sv
// Signed fixed-point multiplier: sign-magnitude shift-add over WIDTH cycles,
// then round-half-away-from-zero, range check and sign restore.
module multiplication
    import multiplication_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH,
    parameter int FBITS = FP_FBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             ovf,
    output logic [WIDTH-1:0] val
);

    localparam int AW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [AW-1:0] HALF_LSB  = AW'(1'b1) << (FBITS - 1);
    localparam logic [AW-1:0] LIMIT_POS = AW'({1'b0, {(WIDTH-1){1'b1}}});
    localparam logic [AW-1:0] LIMIT_NEG = AW'({1'b1, {(WIDTH-1){1'b0}}});

    fp_state_e        state_r;
    logic [AW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [AW-1:0]    acc_r;
    logic [CW-1:0]    cnt_r;
    logic             sign_r;
    logic             ovf_pend_r;

    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic [AW-1:0]    rounded_s;
    logic             range_ovf_s;

    // Operand magnitudes, rounded product magnitude and its range check
    always_comb begin
        abs_a_s     = a[WIDTH-1] ? (~a + WIDTH'(1'b1)) : a;
        abs_b_s     = b[WIDTH-1] ? (~b + WIDTH'(1'b1)) : b;
        rounded_s   = (acc_r + HALF_LSB) >> FBITS;
        range_ovf_s = 1'b0;
        if (sign_r) begin
            range_ovf_s = (rounded_s > LIMIT_NEG);
        end else begin
            range_ovf_s = (rounded_s > LIMIT_POS);
        end
    end

    // Control FSM with inline add-shift datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            mcand_r    <= '0;
            mplier_r   <= '0;
            acc_r      <= '0;
            cnt_r      <= '0;
            sign_r     <= 1'b0;
            ovf_pend_r <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            valid      <= 1'b0;
            ovf        <= 1'b0;
            val        <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_r  <= AW'(abs_a_s);
                        mplier_r <= abs_b_s;
                        sign_r   <= a[WIDTH-1] ^ b[WIDTH-1];
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        busy     <= 1'b1;
                        valid    <= 1'b0;
                        ovf      <= 1'b0;
                        state_r  <= ST_CALC;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end else begin
                        acc_r <= acc_r;
                    end
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1'b1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        state_r <= ST_ROUND;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_ROUND: begin
                    acc_r      <= rounded_s;
                    ovf_pend_r <= range_ovf_s;
                    // A rounded-away result is always reported as +0
                    sign_r     <= sign_r & (rounded_s != '0);
                    state_r    <= ST_SIGN;
                end
                ST_SIGN: begin
                    if (ovf_pend_r) begin
                        val   <= '0;
                        valid <= 1'b0;
                        ovf   <= 1'b1;
                    end else begin
                        val   <= sign_r ? (~acc_r[WIDTH-1:0] + WIDTH'(1'b1)) : acc_r[WIDTH-1:0];
                        valid <= 1'b1;
                        ovf   <= 1'b0;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplication.sv
// Directed bench for the Q16.8 sequential multiplier: hand-computed products,
// rounding and range edges, latency, start handling and asynchronous reset.
module tb_multiplication;

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] a;
    logic [23:0] b;
    logic        busy;
    logic        done;
    logic        valid;
    logic        ovf;
    logic [23:0] val;

    int checks;
    int errors;
    int cyc;
    int done_seen;

    multiplication #(.WIDTH(24), .FBITS(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .ovf   (ovf),
        .val   (val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives start for one accepting edge.
    task automatic start_op(input logic [23:0] av, input logic [23:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", {31'd0, busy}, 32'd1);
        chk("accept_done", {31'd0, done}, 32'd0);
        chk("accept_valid_clr", {31'd0, valid}, 32'd0);
        chk("accept_ovf_clr", {31'd0, ovf}, 32'd0);
    endtask

    // Waits (bounded) for done, optionally pulsing start with junk operands mid-run.
    task automatic wait_done(input logic signed [23:0] ev, input logic evalid,
                             input logic eovf, input int glitch_at);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (cyc == glitch_at);
            if (cyc == glitch_at) begin
                a = 24'h123456;
                b = 24'h654321;
            end
            if (done) break;
        end
        start = 1'b0;
        chk("latency", cyc, 32'd26);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("val", {8'd0, val}, {8'd0, ev});
        chk("valid", {31'd0, valid}, {31'd0, evalid});
        chk("ovf", {31'd0, ovf}, {31'd0, eovf});
    endtask

    task automatic do_op(input logic [23:0] av, input logic [23:0] bv,
                         input logic signed [23:0] ev, input logic evalid, input logic eovf);
        start_op(av, bv);
        wait_done(ev, evalid, eovf, 0);
        @(negedge clk);
        chk("done_low_next", {31'd0, done}, 32'd0);
        chk("val_hold", {8'd0, val}, {8'd0, ev});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        start  = 1'b0;
        a      = 24'd0;
        b      = 24'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_val", {8'd0, val}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(24'd2560, 24'd512, 24'sd5120, 1'b1, 1'b0);
        do_op(-24'sd2560, 24'd512, -24'sd5120, 1'b1, 1'b0);
        do_op(-24'sd640, -24'sd1024, 24'sd2560, 1'b1, 1'b0);
        do_op(24'd0, 24'd1280, 24'sd0, 1'b1, 1'b0);
        do_op(24'd1, 24'd128, 24'sd1, 1'b1, 1'b0);
        do_op(24'd128, 24'd128, 24'sd64, 1'b1, 1'b0);
        do_op(-24'sd1, 24'd1, 24'sd0, 1'b1, 1'b0);
        do_op(24'd8388352, 24'd512, 24'sd0, 1'b0, 1'b1);
        do_op(24'h800000, 24'd256, -24'sd8388608, 1'b1, 1'b0);
        do_op(24'h800000, -24'sd256, 24'sd0, 1'b0, 1'b1);
        do_op(24'd8388607, 24'd256, 24'sd8388607, 1'b1, 1'b0);

        // start pulsed mid-operation with different operands is ignored
        start_op(24'd2560, 24'd512);
        wait_done(24'sd5120, 1'b1, 1'b0, 5);
        @(negedge clk);

        // start in the done cycle is accepted with no dead cycle
        start_op(-24'sd640, -24'sd1024);
        wait_done(24'sd2560, 1'b1, 1'b0, 0);
        start_op(24'd128, 24'd128);
        wait_done(24'sd64, 1'b1, 1'b0, 0);
        @(negedge clk);
        chk("b2b_done_low", {31'd0, done}, 32'd0);

        // asynchronous reset mid-operation
        start_op(24'd2560, 24'd512);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_ovf", {31'd0, ovf}, 32'd0);
        chk("arst_val", {8'd0, val}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            if (done) done_seen++;
        end
        chk("arst_no_done", done_seen, 32'd0);
        do_op(24'd1, 24'd128, 24'sd1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
